// File: rtl/alu_result_stage.sv
// Registered ALU result stage: flag derivation, 2-entry skid buffer, transfer counter.
// Optional even-parity output when ALU_STAGE_PARITY_EN is defined.
//
// state | meaning
// EMPTY | no result held, out_valid=0
// ONE   | head register holds a result
// TWO   | head and skid registers full, in_ready=0
module alu_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] busALU,
  input  logic [2:0]       alu_op,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] busOUT,
  output logic [3:0]       flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count
`ifdef ALU_STAGE_PARITY_EN
  , output logic           parity
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occState_t;

  occState_t        state;
  logic [WIDTH-1:0] skidData;
  logic [3:0]       skidFlags;
  logic             isArith;
  logic [3:0]       newFlags;
  logic             accept;
  logic             deliver;

  assign isArith  = (alu_op == 3'b000) || (alu_op == 3'b001) || (alu_op == 3'b101);
  assign newFlags = {busALU[WIDTH-1], (busALU == '0), isArith & alu_carry, isArith & alu_ovf};
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

`ifdef ALU_STAGE_PARITY_EN
  logic skidPar;
  logic newPar;
  assign newPar = ^busALU;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busOUT     <= '0;
      flags      <= '0;
      skidData   <= '0;
      skidFlags  <= '0;
      xfer_count <= '0;
`ifdef ALU_STAGE_PARITY_EN
      parity     <= 1'b0;
      skidPar    <= 1'b0;
`endif
    end else begin
      if (accept) xfer_count <= xfer_count + CNT_W'(1);
      case (state)
        EMPTY: begin
          if (accept) begin
            busOUT    <= busALU;
            flags     <= newFlags;
`ifdef ALU_STAGE_PARITY_EN
            parity    <= newPar;
`endif
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            busOUT <= busALU;
            flags  <= newFlags;
`ifdef ALU_STAGE_PARITY_EN
            parity <= newPar;
`endif
          end else if (accept) begin
            // Head is stalled, so the new result parks in the skid register.
            skidData  <= busALU;
            skidFlags <= newFlags;
`ifdef ALU_STAGE_PARITY_EN
            skidPar   <= newPar;
`endif
            in_ready  <= 1'b0;
            state     <= TWO;
          end else if (deliver) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (deliver) begin
            busOUT   <= skidData;
            flags    <= skidFlags;
`ifdef ALU_STAGE_PARITY_EN
            parity   <= skidPar;
`endif
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: flag vectors, backpressure, streaming, reset.
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] busALU;
  logic [2:0]  alu_op;
  logic        alu_carry, alu_ovf, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] busOUT;
  logic [3:0]  flags;
  logic [15:0] xfer_count;
`ifdef ALU_STAGE_PARITY_EN
  logic        parity;
`endif

  int nTests = 0;
  int nFail  = 0;
  int expCount = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .busALU(busALU), .alu_op(alu_op),
    .alu_carry(alu_carry), .alu_ovf(alu_ovf), .in_valid(in_valid),
    .in_ready(in_ready), .busOUT(busOUT), .flags(flags),
    .out_valid(out_valid), .out_ready(out_ready), .xfer_count(xfer_count)
`ifdef ALU_STAGE_PARITY_EN
    , .parity(parity)
`endif
  );

  typedef struct {
    logic [31:0] res;
    logic [2:0]  op;
    logic        c;
    logic        v;
    logic [3:0]  expFlags;
    logic        expPar;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] r, input logic [2:0] op, input logic c, input logic v);
    busALU = r; alu_op = op; alu_carry = c; alu_ovf = v; in_valid = 1'b1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    expCount = 0;
  endtask

  initial begin
    vecs[0] = '{32'h01010101, 3'b010, 1'b1, 1'b1, 4'b0000, 1'b0};
    vecs[1] = '{32'hFFFFFFFE, 3'b000, 1'b0, 1'b1, 4'b1001, 1'b1};
    vecs[2] = '{32'h00000000, 3'b010, 1'b0, 1'b0, 4'b0100, 1'b0};
    vecs[3] = '{32'h00000000, 3'b001, 1'b1, 1'b0, 4'b0110, 1'b0};
    vecs[4] = '{32'h00000001, 3'b101, 1'b1, 1'b1, 4'b0011, 1'b1};
    vecs[5] = '{32'h80000000, 3'b100, 1'b1, 1'b1, 4'b1000, 1'b1};
    vecs[6] = '{32'h00000007, 3'b110, 1'b1, 1'b1, 4'b0000, 1'b1};
    vecs[7] = '{32'hFFFFFFFF, 3'b011, 1'b0, 1'b1, 4'b1000, 1'b0};

    rst_n = 1'b0; busALU = '0; alu_op = '0; alu_carry = 0; alu_ovf = 0;
    in_valid = 0; out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_busOUT", busOUT, 32'd0);
    chk("rst_flags", {28'b0, flags}, 32'd0);
    chk("rst_count", {16'b0, xfer_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single-result vectors, one accept then one deliver each
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].res, vecs[i].op, vecs[i].c, vecs[i].v);
      step();
      expCount++;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_bus", i), busOUT, vecs[i].res);
      chk($sformatf("vec%0d_flags", i), {28'b0, flags}, {28'b0, vecs[i].expFlags});
      chk($sformatf("vec%0d_count", i), {16'b0, xfer_count}, expCount);
`ifdef ALU_STAGE_PARITY_EN
      chk($sformatf("vec%0d_parity", i), {31'b0, parity}, {31'b0, vecs[i].expPar});
`endif
      step();
      chk($sformatf("vec%0d_drained", i), {31'b0, out_valid}, 32'd0);
    end

    // Backpressure: A, B fill the stage; C waits upstream
    doReset();
    @(negedge clk);
    out_ready = 1'b0;
    drive(32'hA, 3'b000, 0, 0); step();
    chk("bp_rdy_after_A", {31'b0, in_ready}, 32'd1);
    chk("bp_bus_A", busOUT, 32'hA);
    drive(32'hB, 3'b000, 0, 0); step();
    chk("bp_rdy_after_B", {31'b0, in_ready}, 32'd0);
    chk("bp_bus_hold_A", busOUT, 32'hA);
    drive(32'hC, 3'b000, 0, 0); step();
    chk("bp_C_blocked", {31'b0, in_ready}, 32'd0);
    chk("bp_bus_still_A", busOUT, 32'hA);
    chk("bp_count_2", {16'b0, xfer_count}, 32'd2);
    out_ready = 1'b1; step();
    chk("bp_bus_B", busOUT, 32'hB);
    chk("bp_rdy_restored", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_bus_C", busOUT, 32'hC);
    chk("bp_valid_C", {31'b0, out_valid}, 32'd1);
    chk("bp_count_3", {16'b0, xfer_count}, 32'd3);
    step();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Streaming at one result per cycle
    doReset();
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      drive(i, 3'b000, 0, 0);
      step();
      chk($sformatf("st%0d_bus", i), busOUT, i);
      chk($sformatf("st%0d_rdy", i), {31'b0, in_ready}, 32'd1);
      chk($sformatf("st%0d_valid", i), {31'b0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("st_count_10", {16'b0, xfer_count}, 32'd10);
    chk("st_drained", {31'b0, out_valid}, 32'd0);

    // Reset while TWO holds 5 and 6
    out_ready = 1'b0;
    drive(32'h5, 3'b000, 0, 0); step();
    drive(32'h6, 3'b000, 0, 0); step();
    in_valid = 1'b0;
    chk("mr_full", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_valid", {31'b0, out_valid}, 32'd0);
    chk("mr_rdy", {31'b0, in_ready}, 32'd1);
    chk("mr_count", {16'b0, xfer_count}, 32'd0);
    chk("mr_bus", busOUT, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    drive(32'h7, 3'b000, 0, 0); step();
    in_valid = 1'b0;
    chk("mr_bus_7", busOUT, 32'h7);
    chk("mr_valid_7", {31'b0, out_valid}, 32'd1);
    chk("mr_count_1", {16'b0, xfer_count}, 32'd1);
    step();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
